// File: rtl/qeciphy_rx_channeldecoder_param.sv
// RX channel decoder: validates sync header and XOR checksum of each line word,
// tracks link lock (DISABLED/HUNT/LOCKED/FAULT) and forwards good data frames.
module qeciphy_rx_channeldecoder_param #(
    parameter int DATA_W    = 64,
    parameter int LOCK_CNT  = 4,
    parameter int MAX_ERR   = 3,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [DATA_W-1:0]    tdata_i,
    output logic [DATA_W-1:0]    tdata_o,
    output logic                 tvalid_o,
    output logic                 rx_rdy_o,
    output logic                 remote_rx_rdy_o,
    output logic                 rx_fault_fatal_o,
    output logic [3:0]           rx_error_code_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    localparam int NBYTES = DATA_W / 8;
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(MAX_ERR + 1);

    localparam logic [3:0] CODE_NONE  = 4'h0;
    localparam logic [3:0] CODE_SYNC  = 4'h1;
    localparam logic [3:0] CODE_CSUM  = 4'h2;
    localparam logic [3:0] CODE_FATAL = 4'h3;

    typedef enum logic [1:0] {
        ST_DISABLED,
        ST_HUNT,
        ST_LOCKED,
        ST_FAULT
    } state_t;

    state_t                 state_reg, state_next;
    logic [GOOD_W-1:0]      good_cnt_reg, good_cnt_next;
    logic [BAD_W-1:0]       bad_cnt_reg, bad_cnt_next;
    logic [ERR_CNT_W-1:0]   err_cnt_reg, err_cnt_next;
    logic [3:0]             code_reg, code_next;
    logic                   remote_reg, remote_next;
    logic                   tvalid_reg, tvalid_next;
    logic [DATA_W-1:0]      tdata_reg, tdata_next;

    logic [7:0] byte_arr [NBYTES];
    logic [7:0] hdr;
    logic [7:0] csum_calc;
    logic       sync_ok;
    logic       csum_ok;
    logic       frame_good;

    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_bytes
            assign byte_arr[gi] = tdata_i[gi*8 +: 8];
        end
    endgenerate

    assign hdr = byte_arr[NBYTES-1];

    // Checksum covers every byte except the checksum byte itself (byte 0).
    always_comb begin
        csum_calc = 8'h00;
        for (int i = 1; i < NBYTES; i++) begin
            csum_calc = csum_calc ^ byte_arr[i];
        end
    end

    assign sync_ok    = (hdr[7:2] == 6'b101101);
    assign csum_ok    = (csum_calc == byte_arr[0]);
    assign frame_good = sync_ok && csum_ok;

    always_comb begin
        state_next    = state_reg;
        good_cnt_next = good_cnt_reg;
        bad_cnt_next  = bad_cnt_reg;
        err_cnt_next  = err_cnt_reg;
        code_next     = code_reg;
        remote_next   = remote_reg;
        tvalid_next   = 1'b0;
        tdata_next    = tdata_reg;

        // Disable wins over any frame event evaluated in the same cycle.
        if (!enable_i) begin
            state_next    = ST_DISABLED;
            good_cnt_next = '0;
            bad_cnt_next  = '0;
            err_cnt_next  = '0;
            code_next     = CODE_NONE;
            remote_next   = 1'b0;
        end else begin
            case (state_reg)
                ST_DISABLED: begin
                    state_next = ST_HUNT;
                end
                ST_HUNT: begin
                    if (frame_good) begin
                        if (good_cnt_reg == GOOD_W'(LOCK_CNT - 1)) begin
                            state_next    = ST_LOCKED;
                            good_cnt_next = '0;
                            bad_cnt_next  = '0;
                            remote_next   = hdr[0];
                        end else begin
                            good_cnt_next = good_cnt_reg + GOOD_W'(1);
                        end
                    end else begin
                        good_cnt_next = '0;
                    end
                end
                ST_LOCKED: begin
                    if (frame_good) begin
                        bad_cnt_next = '0;
                        remote_next  = hdr[0];
                        if (hdr[1]) begin
                            tvalid_next = 1'b1;
                            tdata_next  = tdata_i;
                        end
                    end else begin
                        bad_cnt_next = bad_cnt_reg + BAD_W'(1);
                        if (err_cnt_reg != '1) begin
                            err_cnt_next = err_cnt_reg + ERR_CNT_W'(1);
                        end
                        code_next = sync_ok ? CODE_CSUM : CODE_SYNC;
                        if (bad_cnt_reg == BAD_W'(MAX_ERR - 1)) begin
                            state_next   = ST_FAULT;
                            bad_cnt_next = '0;
                            code_next    = CODE_FATAL;
                            remote_next  = 1'b0;
                        end
                    end
                end
                ST_FAULT: begin
                    code_next   = CODE_FATAL;
                    remote_next = 1'b0;
                end
                default: begin
                    state_next = ST_DISABLED;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= ST_DISABLED;
            good_cnt_reg <= '0;
            bad_cnt_reg  <= '0;
            err_cnt_reg  <= '0;
            code_reg     <= CODE_NONE;
            remote_reg   <= 1'b0;
            tvalid_reg   <= 1'b0;
            tdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            good_cnt_reg <= good_cnt_next;
            bad_cnt_reg  <= bad_cnt_next;
            err_cnt_reg  <= err_cnt_next;
            code_reg     <= code_next;
            remote_reg   <= remote_next;
            tvalid_reg   <= tvalid_next;
            tdata_reg    <= tdata_next;
        end
    end

    assign tdata_o          = tdata_reg;
    assign tvalid_o         = tvalid_reg;
    assign rx_rdy_o         = (state_reg == ST_LOCKED);
    assign rx_fault_fatal_o = (state_reg == ST_FAULT);
    assign remote_rx_rdy_o  = remote_reg;
    assign rx_error_code_o  = code_reg;
    assign err_cnt_o        = err_cnt_reg;

endmodule

// File: tb/tb_qeciphy_rx_channeldecoder_param.sv
// Directed, table-driven bench for the RX channel decoder; a second instance
// with a large fault threshold exercises bad-frame counter saturation.
module tb_qeciphy_rx_channeldecoder_param;

    localparam logic [63:0] ZERO    = 64'h0000000000000000;
    localparam logic [63:0] IDLE    = 64'hB5000000000000B5;  // idle, remote rdy=1
    localparam logic [63:0] IDLE_R0 = 64'hB4000000000000B4;  // idle, remote rdy=0
    localparam logic [63:0] DATA    = 64'hB7112233445566C0;
    localparam logic [63:0] CSBAD   = 64'hB5000000000000B4;  // sync ok, checksum wrong
    localparam logic [63:0] SYNCBAD = 64'h0000000000000000;  // checksum ok, sync wrong
    localparam logic [63:0] BOTHBAD = 64'h01000000000000FF;  // both wrong -> sync code

    logic        clk;
    logic        rst;
    logic        en;
    logic [63:0] din;
    logic [63:0] tdata;
    logic        tvalid, rdy, rem, fat;
    logic [3:0]  code;
    logic [7:0]  cnt;

    logic        en2;
    logic [63:0] din2;
    logic [63:0] tdata2;
    logic        tvalid2, rdy2, rem2, fat2;
    logic [3:0]  code2;
    logic [7:0]  cnt2;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] last_fwd;

    typedef struct {
        logic        en;
        logic [63:0] d;
        logic        rdy;
        logic        rem;
        logic        fat;
        logic [3:0]  code;
        logic [7:0]  cnt;
        logic        tv;
    } vec_t;

    vec_t vecs[$];

    qeciphy_rx_channeldecoder_param #(
        .DATA_W(64), .LOCK_CNT(4), .MAX_ERR(3), .ERR_CNT_W(8)
    ) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .tdata_i(din),
        .tdata_o(tdata), .tvalid_o(tvalid), .rx_rdy_o(rdy),
        .remote_rx_rdy_o(rem), .rx_fault_fatal_o(fat),
        .rx_error_code_o(code), .err_cnt_o(cnt)
    );

    qeciphy_rx_channeldecoder_param #(
        .DATA_W(64), .LOCK_CNT(4), .MAX_ERR(1000), .ERR_CNT_W(8)
    ) dut_sat (
        .clk_i(clk), .rst_i(rst), .enable_i(en2), .tdata_i(din2),
        .tdata_o(tdata2), .tvalid_o(tvalid2), .rx_rdy_o(rdy2),
        .remote_rx_rdy_o(rem2), .rx_fault_fatal_o(fat2),
        .rx_error_code_o(code2), .err_cnt_o(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic e, input logic [63:0] d, input logic r, input logic rm,
                       input logic f, input logic [3:0] c, input logic [7:0] n, input logic tv);
        vec_t v;
        v.en = e; v.d = d; v.rdy = r; v.rem = rm; v.fat = f; v.code = c; v.cnt = n; v.tv = tv;
        vecs.push_back(v);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; din = ZERO; en2 = 1'b0; din2 = ZERO;
        last_fwd = '0;

        // Lock and forward
        add(1, ZERO, 0,0,0,4'h0,8'd0,0);
        repeat (3) add(1, IDLE, 0,0,0,4'h0,8'd0,0);
        add(1, IDLE,    1,1,0,4'h0,8'd0,0);
        add(1, DATA,    1,1,0,4'h0,8'd0,1);
        add(1, IDLE,    1,1,0,4'h0,8'd0,0);
        // Hunt reset by a bad frame
        add(0, IDLE,    0,0,0,4'h0,8'd0,0);
        add(1, ZERO,    0,0,0,4'h0,8'd0,0);
        repeat (3) add(1, IDLE, 0,0,0,4'h0,8'd0,0);
        add(1, SYNCBAD, 0,0,0,4'h0,8'd0,0);
        repeat (3) add(1, IDLE, 0,0,0,4'h0,8'd0,0);
        add(1, IDLE,    1,1,0,4'h0,8'd0,0);
        // Errors below threshold, remote flag tracking, code precedence
        add(1, CSBAD,   1,1,0,4'h2,8'd1,0);
        add(1, CSBAD,   1,1,0,4'h2,8'd2,0);
        add(1, IDLE_R0, 1,0,0,4'h2,8'd2,0);
        add(1, DATA,    1,1,0,4'h2,8'd2,1);
        add(1, BOTHBAD, 1,1,0,4'h1,8'd3,0);
        add(1, IDLE,    1,1,0,4'h1,8'd3,0);
        // Fault entry, good frames do not recover
        add(1, CSBAD,   1,1,0,4'h2,8'd4,0);
        add(1, SYNCBAD, 1,1,0,4'h1,8'd5,0);
        add(1, CSBAD,   0,0,1,4'h3,8'd6,0);
        add(1, IDLE,    0,0,1,4'h3,8'd6,0);
        add(1, DATA,    0,0,1,4'h3,8'd6,0);
        add(1, IDLE,    0,0,1,4'h3,8'd6,0);
        // Fault recovery through a 16-cycle disable
        repeat (16) add(0, IDLE, 0,0,0,4'h0,8'd0,0);
        add(1, ZERO,    0,0,0,4'h0,8'd0,0);
        repeat (3) add(1, IDLE, 0,0,0,4'h0,8'd0,0);
        add(1, IDLE,    1,1,0,4'h0,8'd0,0);
        // Single-cycle disable overrides a bad frame, then a lock event
        add(1, CSBAD,   1,1,0,4'h2,8'd1,0);
        add(0, CSBAD,   0,0,0,4'h0,8'd0,0);
        add(1, ZERO,    0,0,0,4'h0,8'd0,0);
        repeat (3) add(1, IDLE, 0,0,0,4'h0,8'd0,0);
        add(0, IDLE,    0,0,0,4'h0,8'd0,0);
        add(1, ZERO,    0,0,0,4'h0,8'd0,0);
        repeat (3) add(1, IDLE, 0,0,0,4'h0,8'd0,0);
        add(1, IDLE,    1,1,0,4'h0,8'd0,0);
        add(1, DATA,    1,1,0,4'h0,8'd0,1);

        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("reset rdy", {63'd0, rdy}, 64'd0);
        chk("reset tvalid", {63'd0, tvalid}, 64'd0);
        chk("reset fatal", {63'd0, fat}, 64'd0);
        chk("reset code", {60'd0, code}, 64'd0);
        chk("reset err_cnt", {56'd0, cnt}, 64'd0);
        chk("reset tdata", tdata, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            en  = vecs[i].en;
            din = vecs[i].d;
            step();
            if (vecs[i].tv) last_fwd = vecs[i].d;
            chk($sformatf("v%0d rdy", i),    {63'd0, rdy},    {63'd0, vecs[i].rdy});
            chk($sformatf("v%0d remote", i), {63'd0, rem},    {63'd0, vecs[i].rem});
            chk($sformatf("v%0d fatal", i),  {63'd0, fat},    {63'd0, vecs[i].fat});
            chk($sformatf("v%0d code", i),   {60'd0, code},   {60'd0, vecs[i].code});
            chk($sformatf("v%0d err_cnt", i),{56'd0, cnt},    {56'd0, vecs[i].cnt});
            chk($sformatf("v%0d tvalid", i), {63'd0, tvalid}, {63'd0, vecs[i].tv});
            chk($sformatf("v%0d tdata", i),  tdata,           last_fwd);
        end

        // Asynchronous reset mid-cycle while tvalid is high
        en = 1'b1; din = IDLE;
        #2 rst = 1'b1;
        #1;
        chk("async rdy", {63'd0, rdy}, 64'd0);
        chk("async remote", {63'd0, rem}, 64'd0);
        chk("async tvalid", {63'd0, tvalid}, 64'd0);
        chk("async tdata", tdata, 64'd0);
        chk("async err_cnt", {56'd0, cnt}, 64'd0);
        step();
        rst = 1'b0;
        step();
        chk("post-reset rdy", {63'd0, rdy}, 64'd0);

        // Saturating bad-frame counter
        en2 = 1'b1; din2 = ZERO;
        step();
        din2 = IDLE;
        repeat (4) step();
        chk("sat lock rdy", {63'd0, rdy2}, 64'd1);
        din2 = CSBAD;
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 253) chk("sat cnt 254", {56'd0, cnt2}, 64'd254);
        end
        chk("sat cnt final", {56'd0, cnt2}, 64'd255);
        chk("sat rdy", {63'd0, rdy2}, 64'd1);
        chk("sat fatal", {63'd0, fat2}, 64'd0);
        chk("sat code", {60'd0, code2}, 64'd2);
        chk("sat tvalid", {63'd0, tvalid2}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
